// File: rtl/ps2_pkg.sv
// Scan-code constants, decoder state encoding, event record layout and scan->ASCII map.
// Pure declarations: no latency of its own.
// No handshake of its own; shared by the decoder, its FIFO and the interface users.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_t;

    typedef struct packed {
        logic       make;
        logic       ext;
        logic [7:0] code;
        logic [7:0] ascii;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    // Set-2 scan codes; letters are mapped lower case first and shifted down by 0x20 when upper.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] lc;
        logic       is_letter;
        lc        = 8'h00;
        is_letter = 1'b1;
        case (code)
            8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
            8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
            8'h43: lc = 8'h69;  8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;  8'h4D: lc = 8'h70;
            8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;  8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;
            8'h3C: lc = 8'h75;  8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
            default: is_letter = 1'b0;
        endcase
        if (is_letter) begin
            return upper ? (lc - 8'h20) : lc;
        end
        case (code)
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;  8'h26: return 8'h33;
            8'h25: return 8'h34;  8'h2E: return 8'h35;  8'h36: return 8'h36;  8'h3D: return 8'h37;
            8'h3E: return 8'h38;  8'h46: return 8'h39;
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Receiver-side byte handshake plus the ready/valid key-event output bundle.
// No latency: wiring only.
// master = decoder, slave = keyboard receiver / event consumer side.
interface ps2_key_event_decoder_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int COUNT_W    = $clog2(FIFO_DEPTH) + 1
);
    logic [7:0]         ps2_data_in;
    logic               ps2_ready;
    logic               ps2_nextdata_n;
    logic               evt_valid;
    logic               evt_ready;
    logic               evt_make;
    logic               evt_ext;
    logic [7:0]         evt_code;
    logic [7:0]         evt_ascii;
    logic [COUNT_W-1:0] evt_count;

    modport master (
        input  ps2_data_in, ps2_ready, evt_ready,
        output ps2_nextdata_n, evt_valid, evt_make, evt_ext, evt_code, evt_ascii, evt_count
    );

    modport slave (
        output ps2_data_in, ps2_ready, evt_ready,
        input  ps2_nextdata_n, evt_valid, evt_make, evt_ext, evt_code, evt_ascii, evt_count
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous ready/valid event queue with a registered head (read) port.
// Latency: entry written at edge W is visible on rd_vld after edge W+1.
// Backpressure: full when count==DEPTH; a same-cycle pop does not free a slot.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_after_pop;
    logic             push;
    logic             pop;

    assign full          = (cnt == CNT_W'(DEPTH));
    assign push          = wr_vld && !full;
    assign pop           = rd_vld && rd_rdy;
    assign rd_ptr_nxt    = rd_ptr + PTR_W'(pop);
    assign cnt_after_pop = cnt - CNT_W'(pop);
    assign count         = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Head reloads only from entries that already existed before this edge, so a
    // fresh write always takes one extra cycle to reach the read port.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_after_pop + CNT_W'(push);
            rd_vld <= (cnt_after_pop != '0);
            rd_dat <= (cnt_after_pop != '0) ? mem[rd_ptr_nxt] : '0;
        end
    end
endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan bytes -> queued key events (make/break, ext, code, ASCII); TYPEMATIC_FILTER_EN drops auto-repeat makes.
// Latency: byte accepted at edge N is written at N+1 and visible on evt_valid after N+2.
// Backpressure: event bytes wait with ps2_nextdata_n high while the FIFO is full; prefixes never wait.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int COUNT_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    ps2_key_event_decoder_if.master bus
);
    ps2_state_t         state;
    logic               nextdata_n_q;
    logic               lshift;
    logic               rshift;
    logic               caps;
    logic               caps_held;
    logic               push_vld;
    evt_t               push_dat;
    logic               fifo_full;
    logic               head_vld;
    evt_t               head;
    logic [COUNT_W-1:0] fifo_count;
`ifdef TYPEMATIC_FILTER_EN
    logic [127:0]       held;
`endif

    logic [7:0] b;
    logic       is_drop;
    logic       is_prefix;
    logic       ext_c;
    logic       make_c;
    logic       filtered;
    logic       needs_space;
    logic       accept;
    logic [7:0] ascii_c;

    assign b = bus.ps2_data_in;

    always_comb begin
        is_drop   = b inside {SC_ACK, SC_BAT, SC_PAUSE, SC_ERR0, SC_ERR1};
        is_prefix = ((state == ST_IDLE) && ((b == SC_EXT) || (b == SC_BRK))) ||
                    ((state == ST_EXT)  && (b == SC_BRK));
        ext_c     = (state == ST_EXT) || (state == ST_EXT_BRK);
        make_c    = (state == ST_IDLE) || (state == ST_EXT);
        ascii_c   = ext_c ? 8'h00 : scan_to_ascii(b, (lshift | rshift) ^ caps);
`ifdef TYPEMATIC_FILTER_EN
        filtered  = !ext_c && make_c && !b[7] && held[b[6:0]];
`else
        filtered  = 1'b0;
`endif
        needs_space = !is_drop && !is_prefix && !filtered;
        accept      = en && bus.ps2_ready && nextdata_n_q && !(needs_space && fifo_full);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= ST_IDLE;
            nextdata_n_q <= 1'b1;
            lshift       <= 1'b0;
            rshift       <= 1'b0;
            caps         <= 1'b0;
            caps_held    <= 1'b0;
            push_vld     <= 1'b0;
            push_dat     <= '0;
`ifdef TYPEMATIC_FILTER_EN
            held         <= '0;
`endif
        end else begin
            // Strobe low for one cycle only; it gates accept, so no byte is taken twice.
            nextdata_n_q <= !accept;
            push_vld     <= accept && needs_space;
            if (accept) begin
                if (is_drop) begin
                    state <= ST_IDLE;
                end else if (is_prefix) begin
                    if (b == SC_EXT) begin
                        state <= ST_EXT;
                    end else if (state == ST_EXT) begin
                        state <= ST_EXT_BRK;
                    end else begin
                        state <= ST_BRK;
                    end
                end else begin
                    state <= ST_IDLE;
                    if (needs_space) begin
                        push_dat <= {make_c, ext_c, b, ascii_c};
                    end
                    if (needs_space && !ext_c) begin
                        if (b == SC_LSHIFT) lshift <= make_c;
                        if (b == SC_RSHIFT) rshift <= make_c;
                        if (b == SC_CAPS) begin
                            if (make_c && !caps_held) caps <= !caps;
                            caps_held <= make_c;
                        end
`ifdef TYPEMATIC_FILTER_EN
                        if (!b[7]) held[b[6:0]] <= make_c;
`endif
                    end
                end
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W),
        .CNT_W (COUNT_W)
    ) u_fifo (
        .clk    (clk),
        .clr    (clr),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .full   (fifo_full),
        .rd_vld (head_vld),
        .rd_rdy (bus.evt_ready),
        .rd_dat (head),
        .count  (fifo_count)
    );

    assign bus.ps2_nextdata_n = nextdata_n_q;
    assign bus.evt_valid      = head_vld;
    assign bus.evt_make       = head.make;
    assign bus.evt_ext        = head.ext;
    assign bus.evt_code       = head.code;
    assign bus.evt_ascii      = head.ascii;
    assign bus.evt_count      = fifo_count;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench: expected events queued as bytes are sent, popped on each consumer handshake.
module tb_ps2_key_event_decoder;
    logic clk;
    logic clr;
    logic en;

    ps2_key_event_decoder_if bus();

    ps2_key_event_decoder dut (
        .clk (clk),
        .clr (clr),
        .en  (en),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses  = 0;
    int          bytes_sent = 0;
    logic [17:0] sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed still running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_push(input logic mk, input logic ex, input logic [7:0] code, input logic [7:0] asc);
        sb.push_back({mk, ex, code, asc});
    endtask

    // Keyboard model: holds ready with the byte until the strobe goes low.
    task automatic send_byte(input logic [7:0] v);
        bit done;
        done = 1'b0;
        bus.ps2_data_in = v;
        bus.ps2_ready   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ps2_nextdata_n === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        bus.ps2_ready = 1'b0;
        if (done) bytes_sent++;
        check("byte_accept_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && bus.evt_count == 0 && bus.evt_valid === 1'b0) break;
            @(negedge clk);
        end
        check(tag, sb.size(), 0);
    endtask

    // Consumer-side monitor sampling just before each rising edge.
    initial begin
        logic [17:0] got;
        logic [17:0] want;
        forever begin
            @(negedge clk);
            #4;
            if (clr === 1'b0) begin
                if (bus.ps2_nextdata_n === 1'b0) pulses++;
                if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
                    got = {bus.evt_make, bus.evt_ext, bus.evt_code, bus.evt_ascii};
                    n_tests++;
                    assert (sb.size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_evt: observed %h expected no event", got);
                    end
                    if (sb.size() != 0) begin
                        want = sb.pop_front();
                        check("evt", {14'd0, got}, {14'd0, want});
                    end
                end
            end
        end
    end

    logic [7:0] fill_codes [8];
    logic [7:0] fill_ascii [8];
    int         p0;

    initial begin
        fill_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
        fill_ascii = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74, 8'h79, 8'h75, 8'h69};
        clr = 1'b1;
        en  = 1'b1;
        bus.ps2_data_in = 8'h00;
        bus.ps2_ready   = 1'b0;
        bus.evt_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nextdata_n", bus.ps2_nextdata_n, 1);
        check("rst_valid", bus.evt_valid, 0);
        check("rst_count", bus.evt_count, 0);
        check("rst_head", {bus.evt_make, bus.evt_ext, bus.evt_code, bus.evt_ascii}, 0);
        clr = 1'b0;
        @(negedge clk);

        // Basic make/break with latency probe on the first event.
        exp_push(1, 0, 8'h1C, 8'h61);
        send_byte(8'h1C);
        check("lat_n0_valid", bus.evt_valid, 0);
        @(negedge clk);
        check("lat_n1_valid", bus.evt_valid, 0);
        check("lat_n1_count", bus.evt_count, 1);
        @(negedge clk);
        check("lat_n2_valid", bus.evt_valid, 1);
        check("lat_n2_code", bus.evt_code, 8'h1C);
        bus.evt_ready = 1'b1;
        exp_push(0, 0, 8'h1C, 8'h61);
        send_byte(8'hF0);
        send_byte(8'h1C);
        wait_drain("drain_basic");
        check("pulses_basic", pulses, 3);

        // Shift and caps.
        exp_push(1, 0, 8'h12, 8'h00); send_byte(8'h12);
        exp_push(1, 0, 8'h1C, 8'h41); send_byte(8'h1C);
        exp_push(0, 0, 8'h1C, 8'h41); send_byte(8'hF0); send_byte(8'h1C);
        exp_push(0, 0, 8'h12, 8'h00); send_byte(8'hF0); send_byte(8'h12);
        exp_push(1, 0, 8'h1C, 8'h61); send_byte(8'h1C);
        exp_push(0, 0, 8'h1C, 8'h61); send_byte(8'hF0); send_byte(8'h1C);
        exp_push(1, 0, 8'h58, 8'h00); send_byte(8'h58);
        exp_push(0, 0, 8'h58, 8'h00); send_byte(8'hF0); send_byte(8'h58);
        exp_push(1, 0, 8'h1C, 8'h41); send_byte(8'h1C);
        exp_push(0, 0, 8'h1C, 8'h41); send_byte(8'hF0); send_byte(8'h1C);
        exp_push(1, 0, 8'h59, 8'h00); send_byte(8'h59);
        exp_push(1, 0, 8'h1C, 8'h61); send_byte(8'h1C);
        exp_push(0, 0, 8'h1C, 8'h61); send_byte(8'hF0); send_byte(8'h1C);
        exp_push(0, 0, 8'h59, 8'h00); send_byte(8'hF0); send_byte(8'h59);
        exp_push(1, 0, 8'h58, 8'h00); send_byte(8'h58);
        exp_push(0, 0, 8'h58, 8'h00); send_byte(8'hF0); send_byte(8'h58);
        wait_drain("drain_modifiers");

        // Extended make/break.
        exp_push(1, 1, 8'h75, 8'h00); send_byte(8'hE0); send_byte(8'h75);
        exp_push(0, 1, 8'h75, 8'h00); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        wait_drain("drain_ext");

        // Fill the queue, then hold the ninth byte until one pop frees a slot.
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_push(1, 0, fill_codes[i], fill_ascii[i]);
            send_byte(fill_codes[i]);
        end
        exp_push(1, 0, 8'h44, 8'h6F);
        bus.ps2_data_in = 8'h44;
        bus.ps2_ready   = 1'b1;
        repeat (6) @(negedge clk);
        check("full_count", bus.evt_count, 8);
        check("full_hold", bus.ps2_nextdata_n, 1);
        check("full_valid", bus.evt_valid, 1);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        check("pop_count", bus.evt_count, 7);
        check("pop_not_yet", bus.ps2_nextdata_n, 1);
        @(negedge clk);
        check("accept_after_pop", bus.ps2_nextdata_n, 0);
        bus.ps2_ready = 1'b0;
        bytes_sent++;
        repeat (3) @(negedge clk);
        check("refill_count", bus.evt_count, 8);
        bus.evt_ready = 1'b1;
        wait_drain("drain_full");

        // en=0 holds the E0 prefix across the pause.
        send_byte(8'hE0);
        en = 1'b0;
        bus.ps2_data_in = 8'h6B;
        bus.ps2_ready   = 1'b1;
        @(negedge clk);
        p0 = pulses;
        repeat (4) @(negedge clk);
        check("en0_no_accept", pulses - p0, 0);
        en = 1'b1;
        exp_push(1, 1, 8'h6B, 8'h00); send_byte(8'h6B);
        exp_push(0, 1, 8'h6B, 8'h00); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        wait_drain("drain_en");

        // clr discards a queued event and a pending prefix.
        bus.evt_ready = 1'b0;
        send_byte(8'h1C);
        send_byte(8'hE0);
        repeat (2) @(negedge clk);
        check("pre_clr_count", bus.evt_count, 1);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        check("post_clr_count", bus.evt_count, 0);
        check("post_clr_valid", bus.evt_valid, 0);
        bus.evt_ready = 1'b1;
        exp_push(1, 0, 8'h6B, 8'h00); send_byte(8'h6B);
        exp_push(0, 0, 8'h6B, 8'h00); send_byte(8'hF0); send_byte(8'h6B);
        wait_drain("drain_clr");

        // Auto-repeat makes.
        exp_push(1, 0, 8'h1C, 8'h61);
`ifndef TYPEMATIC_FILTER_EN
        exp_push(1, 0, 8'h1C, 8'h61);
        exp_push(1, 0, 8'h1C, 8'h61);
`endif
        exp_push(0, 0, 8'h1C, 8'h61);
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        wait_drain("drain_typematic");

        // Drop codes produce nothing and cancel a pending prefix.
        send_byte(8'hFA);
        send_byte(8'hAA);
        send_byte(8'hE0);
        send_byte(8'hFA);
        exp_push(1, 0, 8'h1C, 8'h61); send_byte(8'h1C);
        exp_push(0, 0, 8'h1C, 8'h61); send_byte(8'hF0); send_byte(8'h1C);

        // Digits and the special mappings.
        exp_push(1, 0, 8'h16, 8'h31); send_byte(8'h16);
        exp_push(1, 0, 8'h45, 8'h30); send_byte(8'h45);
        exp_push(1, 0, 8'h29, 8'h20); send_byte(8'h29);
        exp_push(1, 0, 8'h5A, 8'h0D); send_byte(8'h5A);
        exp_push(1, 0, 8'h66, 8'h08); send_byte(8'h66);
        wait_drain("drain_final");
        repeat (2) @(negedge clk);
        check("pulses_total", pulses, bytes_sent);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
